// File: rtl/cr_huf_comp_sc_rd_sched.sv
// ---------------------------------------------------------------------------
// cr_huf_comp_sc_rd_sched
//
// Read scheduler for the short and long symbol-count FIFOs that sit between
// the symbol-map and input-sequencer stages. For each frame it pops every
// short entry up to and including the one carrying a nonzero eob. It then
// pops every long entry up to its eob, unless the frame was flagged as having
// no long stream. All popped entries go out on one registered valid/ready
// stream. Every long entry's seq_id is compared against the seq_id of the
// frame's first short entry, and any mismatch sets a sticky error flag.
//
// Optional feature macro: CR_HUF_COMP_SC_RD_SCHED_STATS_EN
//   When defined, the block adds free-running 16-bit statistics counters
//   (completed frames, short pops, long pops).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   short_vld/data/seq_id/eob  show-ahead head of the short FIFO
//   short_rd                   pop strobe for the short FIFO (combinational)
//   long_vld/data/seq_id/eob   show-ahead head of the long FIFO
//   long_rd                    pop strobe for the long FIFO (combinational)
//   skip_long                  frame has no long stream; sampled on IDLE->SHORT
//   out_vld/out_rdy            output handshake
//   out_src                    0 = entry came from short, 1 = from long
//   out_data/seq_id/eob        registered output entry
//   seq_err                    sticky long/short seq_id mismatch
//   stat_frames/short/long     (STATS_EN only) statistics counters
// ---------------------------------------------------------------------------
module cr_huf_comp_sc_rd_sched #(
  parameter int DATA_W = 9,
  parameter int SEQ_W  = 4,
  parameter int EOB_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              short_vld,
  input  logic [DATA_W-1:0] short_data,
  input  logic [SEQ_W-1:0]  short_seq_id,
  input  logic [EOB_W-1:0]  short_eob,
  output logic              short_rd,
  input  logic              long_vld,
  input  logic [DATA_W-1:0] long_data,
  input  logic [SEQ_W-1:0]  long_seq_id,
  input  logic [EOB_W-1:0]  long_eob,
  output logic              long_rd,
  input  logic              skip_long,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_src,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  out_seq_id,
  output logic [EOB_W-1:0]  out_eob,
  output logic              seq_err
`ifdef CR_HUF_COMP_SC_RD_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_short,
  output logic [15:0]       stat_long
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                skip_q, skip_d;
  logic                first_q, first_d;
  logic [SEQ_W-1:0]    frame_seq_q, frame_seq_d;
  logic                seq_err_q, seq_err_d;

  logic                out_vld_q, out_vld_d;
  logic                out_src_q, out_src_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEQ_W-1:0]    out_seq_q, out_seq_d;
  logic [EOB_W-1:0]    out_eob_q, out_eob_d;

  logic                load_ok_s;
  logic                short_eob_s;
  logic                long_eob_s;

  // The output register can take a new entry when empty or being drained.
  assign load_ok_s   = !out_vld_q || out_rdy;
  assign short_eob_s = (short_eob != {EOB_W{1'b0}});
  assign long_eob_s  = (long_eob != {EOB_W{1'b0}});

  // Next-state, pop strobes and frame bookkeeping.
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    first_d     = first_q;
    frame_seq_d = frame_seq_q;
    short_rd    = 1'b0;
    long_rd     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // There is no pop in IDLE, so each frame starts with one bubble cycle.
        if (short_vld) begin
          state_d = ST_SHORT;
          skip_d  = skip_long;
          first_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHORT: begin
        if (short_vld && load_ok_s) begin
          short_rd = 1'b1;
          first_d  = 1'b0;
          if (first_q) begin
            frame_seq_d = short_seq_id;
          end else begin
            frame_seq_d = frame_seq_q;
          end
          if (short_eob_s) begin
            state_d = skip_q ? ST_IDLE : ST_LONG;
          end else begin
            state_d = ST_SHORT;
          end
        end else begin
          state_d = ST_SHORT;
        end
      end
      ST_LONG: begin
        if (long_vld && load_ok_s) begin
          long_rd = 1'b1;
          if (long_eob_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LONG;
          end
        end else begin
          state_d = ST_LONG;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register load/hold/drain and sticky seq_id mismatch.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_src_d  = out_src_q;
    out_data_d = out_data_q;
    out_seq_d  = out_seq_q;
    out_eob_d  = out_eob_q;
    seq_err_d  = seq_err_q;
    if (short_rd) begin
      out_vld_d  = 1'b1;
      out_src_d  = 1'b0;
      out_data_d = short_data;
      out_seq_d  = short_seq_id;
      out_eob_d  = short_eob;
    end else if (long_rd) begin
      out_vld_d  = 1'b1;
      out_src_d  = 1'b1;
      out_data_d = long_data;
      out_seq_d  = long_seq_id;
      out_eob_d  = long_eob;
      // The entry is still forwarded when its seq_id mismatches.
      if (long_seq_id != frame_seq_q) begin
        seq_err_d = 1'b1;
      end else begin
        seq_err_d = seq_err_q;
      end
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= 1'b0;
      first_q     <= 1'b0;
      frame_seq_q <= {SEQ_W{1'b0}};
      seq_err_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_src_q   <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_seq_q   <= {SEQ_W{1'b0}};
      out_eob_q   <= {EOB_W{1'b0}};
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      first_q     <= first_d;
      frame_seq_q <= frame_seq_d;
      seq_err_q   <= seq_err_d;
      out_vld_q   <= out_vld_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
      out_seq_q   <= out_seq_d;
      out_eob_q   <= out_eob_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_src    = out_src_q;
  assign out_data   = out_data_q;
  assign out_seq_id = out_seq_q;
  assign out_eob    = out_eob_q;
  assign seq_err    = seq_err_q;

`ifdef CR_HUF_COMP_SC_RD_SCHED_STATS_EN
  logic [15:0] stat_frames_q;
  logic [15:0] stat_short_q;
  logic [15:0] stat_long_q;
  logic        frame_done_s;

  // A frame completes when the FSM returns to IDLE from an active state.
  assign frame_done_s = (state_q != ST_IDLE) && (state_d == ST_IDLE);

  // Statistics counters; they wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= 16'd0;
      stat_short_q  <= 16'd0;
      stat_long_q   <= 16'd0;
    end else begin
      if (frame_done_s) begin
        stat_frames_q <= stat_frames_q + 16'd1;
      end
      if (short_rd) begin
        stat_short_q <= stat_short_q + 16'd1;
      end
      if (long_rd) begin
        stat_long_q <= stat_long_q + 16'd1;
      end
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_short  = stat_short_q;
  assign stat_long   = stat_long_q;
`endif

endmodule
